// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Loads a program into the instruction memory before the CPU runs.
//   Bytes arrive over a valid/ready handshake, high byte of each word first.
//   Each byte pair is packed into a 16-bit word. Words are written to
//   consecutive word addresses starting at 0. The load ends after the halt
//   word 16'hFFFF has been written. The CPU stays held until the load has
//   completed successfully.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When this macro is defined, the loader keeps a running XOR of every
//   accepted program byte. After the halt word it accepts one check byte.
//   If the check byte does not match the running XOR, the load ends in ERROR.
//
// Parameters
//   DEPTH   instruction memory depth in 16-bit words
//   ADDR_W  word-address width; must equal clog2(DEPTH)
//
// Ports
//   i_clock        system clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_in_valid     source presents a byte on i_in_byte
//   i_in_byte      program byte (high byte of each word first)
//   o_in_ready     loader accepts a byte this cycle
//   i_restart      one-cycle pulse: leave DONE/ERROR and reload from word 0
//   o_wr_en        IMemory write strobe, one cycle per word
//   o_wr_addr      IMemory word address
//   o_wr_data      instruction word
//   o_cpu_hold     1 = CPU frozen (every state except DONE)
//   o_done         load completed successfully (sticky)
//   o_error        overflow or checksum mismatch (sticky)
//   o_word_count   words written in the current load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_byte,
  output logic              o_in_ready,
  input  logic              i_restart,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [15:0]       HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    S_LOAD_HI = 3'd0,
    S_LOAD_LO = 3'd1,
    S_WRITE   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK   = 3'd3,
`endif
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t              r_state, w_state_next;
  logic [7:0]          r_hi, w_hi_next;
  logic [15:0]         r_wr_data, w_wr_data_next;
  logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_next;
  logic [ADDR_W:0]     r_word_count, w_word_count_next;
  logic                r_in_ready, w_in_ready_next;
  logic                r_wr_en, w_wr_en_next;
  logic                r_cpu_hold, w_cpu_hold_next;
  logic                r_done, w_done_next;
  logic                r_error, w_error_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          r_xor, w_xor_next;
`endif

  // A byte moves only when the registered ready and the source valid agree.
  logic w_xfer;
  assign w_xfer = i_in_valid & r_in_ready;

  always_comb begin
    w_state_next      = r_state;
    w_hi_next         = r_hi;
    w_wr_data_next    = r_wr_data;
    w_wr_addr_next    = r_wr_addr;
    w_word_count_next = r_word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    w_xor_next        = r_xor;
`endif

    case (r_state)
      S_LOAD_HI: begin
        if (w_xfer) begin
          w_hi_next    = i_in_byte;
          w_state_next = S_LOAD_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_xor_next   = r_xor ^ i_in_byte;
`endif
        end
      end

      S_LOAD_LO: begin
        if (w_xfer) begin
          w_wr_data_next = {r_hi, i_in_byte};
          w_state_next   = S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_xor_next     = r_xor ^ i_in_byte;
`endif
        end
      end

      // The write strobe is high during this single cycle. Advance the
      // address on exit. The overflowing word is still written before
      // the loader enters ERROR.
      S_WRITE: begin
        w_wr_addr_next    = r_wr_addr + 1'b1;
        w_word_count_next = r_word_count + 1'b1;
        if (r_wr_data == HALT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_next = S_CHECK;
`else
          w_state_next = S_DONE;
`endif
        end else if (r_wr_addr == LAST_ADDR) begin
          w_state_next = S_ERROR;
        end else begin
          w_state_next = S_LOAD_HI;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_xfer) begin
          w_state_next = (i_in_byte == r_xor) ? S_DONE : S_ERROR;
        end
      end
`endif

      S_DONE, S_ERROR: begin
        if (i_restart) begin
          w_state_next      = S_LOAD_HI;
          w_wr_addr_next    = '0;
          w_word_count_next = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_xor_next        = '0;
`endif
        end
      end

      default: begin
        w_state_next = S_LOAD_HI;
      end
    endcase

    // The outputs are decoded from the next state. They are then
    // registered, so each output matches the state it describes.
    w_in_ready_next = (w_state_next == S_LOAD_HI) || (w_state_next == S_LOAD_LO);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (w_state_next == S_CHECK) begin
      w_in_ready_next = 1'b1;
    end
`endif
    w_wr_en_next    = (w_state_next == S_WRITE);
    w_cpu_hold_next = (w_state_next != S_DONE);
    w_done_next     = (w_state_next == S_DONE);
    w_error_next    = (w_state_next == S_ERROR);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_LOAD_HI;
      r_hi         <= '0;
      r_wr_data    <= '0;
      r_wr_addr    <= '0;
      r_word_count <= '0;
      r_in_ready   <= 1'b1;
      r_wr_en      <= 1'b0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor        <= '0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_hi         <= w_hi_next;
      r_wr_data    <= w_wr_data_next;
      r_wr_addr    <= w_wr_addr_next;
      r_word_count <= w_word_count_next;
      r_in_ready   <= w_in_ready_next;
      r_wr_en      <= w_wr_en_next;
      r_cpu_hold   <= w_cpu_hold_next;
      r_done       <= w_done_next;
      r_error      <= w_error_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor        <= w_xor_next;
`endif
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. Programs are byte queues. A small
//   reference model turns each queue into the expected list of writes and
//   the expected final status. A monitor captures the writes the loader
//   actually issues. Inputs are driven and outputs sampled on the falling
//   clock edge.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              restart;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_in_valid   (in_valid),
    .i_in_byte    (in_byte),
    .o_in_ready   (in_ready),
    .i_restart    (restart),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_cpu_hold   (cpu_hold),
    .o_done       (done),
    .o_error      (error),
    .o_word_count (word_count)
  );

  int tests = 0;
  int fails = 0;

  // Captured writes.
  int got_addr[$];
  int got_data[$];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_addr.push_back(int'(wr_addr));
      got_data.push_back(int'(wr_data));
    end
  end

  // Program and model results.
  logic [7:0] prog[$];
  int         exp_addr[$];
  int         exp_data[$];
  int         exp_used;
  logic       exp_halt;
  logic [7:0] exp_xor;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pair bytes into words, stop at the halt word or when memory is full.
  task automatic model();
    logic [15:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_used = 0;
    exp_halt = 1'b0;
    exp_xor  = 8'h00;
    for (int i = 0; i + 1 < prog.size(); i += 2) begin
      w = {prog[i], prog[i+1]};
      exp_addr.push_back(i / 2);
      exp_data.push_back(int'(w));
      exp_xor  = exp_xor ^ prog[i] ^ prog[i+1];
      exp_used = i + 2;
      if (w == 16'hFFFF) begin
        exp_halt = 1'b1;
        break;
      end
      if (i / 2 == DEPTH - 1) break;
    end
  endtask

  // Called just after a falling edge. Returns just after the falling edge
  // that follows the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   {31'd0, in_ready}, 32'd1);
    check({tag, "_wr_en"},      {31'd0, wr_en},    32'd0);
    check({tag, "_wr_addr"},    32'(wr_addr),      32'd0);
    check({tag, "_wr_data"},    32'(wr_data),      32'd0);
    check({tag, "_cpu_hold"},   {31'd0, cpu_hold}, 32'd1);
    check({tag, "_done"},       {31'd0, done},     32'd0);
    check({tag, "_error"},      {31'd0, error},    32'd0);
    check({tag, "_word_count"}, 32'(word_count),   32'd0);
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check({tag, "_rs_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_rs_done"},  {31'd0, done},     32'd0);
    check({tag, "_rs_error"}, {31'd0, error},    32'd0);
    check({tag, "_rs_hold"},  {31'd0, cpu_hold}, 32'd1);
    check({tag, "_rs_count"}, 32'(word_count),   32'd0);
    check({tag, "_rs_addr"},  32'(wr_addr),      32'd0);
  endtask

  // Stream the current program with random gaps in [min_gap, max_gap]
  // before each byte, then compare the writes and the final status with the model.
  task automatic run_load(input string tag, input int min_gap, input int max_gap, input logic bad_chk);
    int   g;
    int   n;
    logic exp_ok;
    got_addr.delete();
    got_data.delete();
    model();
    for (int i = 0; i < exp_used; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, min_gap)) : 0;
      in_valid = 1'b0;
      for (int k = 0; k < g; k++) begin
        @(negedge clk);
        if (i % 2 == 1) check({tag, "_early_write"}, {31'd0, wr_en}, 32'd0);
      end
      send_byte(prog[i]);
      if (i % 2 == 1) begin
        check({tag, "_lat_wr_en"}, {31'd0, wr_en}, 32'd1);
        check({tag, "_lat_addr"},  32'(wr_addr),   exp_addr[i/2]);
        check({tag, "_lat_data"},  32'(wr_data),   exp_data[i/2]);
      end
    end
    exp_ok = exp_halt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (exp_halt) begin
      send_byte(bad_chk ? (exp_xor ^ 8'h01) : exp_xor);
      exp_ok = !bad_chk;
    end
`endif
    n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"},     {31'd0, done},     {31'd0, exp_ok});
    check({tag, "_error"},    {31'd0, error},    {31'd0, !exp_ok});
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_ok});
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_count"},    32'(word_count),   exp_addr.size());
    check({tag, "_nwrites"},  got_addr.size(),   exp_addr.size());
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      check({tag, "_waddr"}, got_addr[k], exp_addr[k]);
      check({tag, "_wdata"}, got_data[k], exp_data[k]);
    end
    // While the loader is in DONE or ERROR, it must ignore in_valid.
    in_valid = 1'b1;
    in_byte  = 8'h5A;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_idle_nwrites"}, got_addr.size(),   exp_addr.size());
    check({tag, "_idle_ready"},   {31'd0, in_ready}, 32'd0);
    check({tag, "_idle_done"},    {31'd0, done},     {31'd0, exp_ok});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nw;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    restart  = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic two-word load.
    prog = '{8'h00, 8'h05, 8'hFF, 8'hFF};
    run_load("basic", 0, 0, 1'b0);

    // Restart from DONE.
    do_restart("restart");
    prog = '{8'hAB, 8'hCD, 8'hFF, 8'hFF};
    run_load("restart", 0, 0, 1'b0);

    // Stall of four cycles before every byte, including between hi and lo.
    do_restart("stall");
    prog = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF};
    run_load("stall", 4, 4, 1'b0);

    // Random programs with random gaps and trailing junk after the halt word.
    for (int r = 0; r < 6; r++) begin
      do_restart("rand");
      prog.delete();
      nw = int'($urandom_range(30, 1));
      for (int k = 0; k < nw; k++) begin
        logic [15:0] w;
        w = 16'($urandom_range(16'hFFFE, 0));
        prog.push_back(w[15:8]);
        prog.push_back(w[7:0]);
      end
      prog.push_back(8'hFF);
      prog.push_back(8'hFF);
      prog.push_back(8'($urandom));
      prog.push_back(8'($urandom));
      run_load("rand", 0, 3, 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_restart("chk_good");
    prog = '{8'h12, 8'h34, 8'hFF, 8'hFF};
    run_load("chk_good", 0, 0, 1'b0);
    do_restart("chk_bad");
    run_load("chk_bad", 0, 0, 1'b1);
`endif

    // Overflow: the memory fills without a halt word.
    do_restart("overflow");
    prog.delete();
    for (int k = 0; k < DEPTH + 2; k++) begin
      logic [15:0] w;
      w = 16'($urandom_range(16'hFFFE, 0));
      prog.push_back(w[15:8]);
      prog.push_back(w[7:0]);
    end
    run_load("overflow", 0, 0, 1'b0);
    check("overflow_last_addr", (got_addr.size() > 0) ? got_addr[got_addr.size()-1] : -1, DEPTH - 1);

    // Reset after a partial word: the dangling high byte must never reach memory.
    do_restart("midreset");
    send_byte(8'h71);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst = 1'b0;
    prog = '{8'h00, 8'h01, 8'hFF, 8'hFF};
    run_load("midreset", 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
